// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-MM master port between instruction fetch
// and the data path. One non-pipelined transfer at a time. Data normally wins,
// but fetch is guaranteed a grant after MAX_D_BURST data grants in a row while
// it waits. A transfer stalled for TIMEOUT waitrequest cycles is abandoned.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic                timeout_err
);

  localparam int DC_W = $clog2(MAX_D_BURST + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t            r_state;
  logic [DC_W-1:0]   r_dcnt;
  logic [WC_W-1:0]   r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_read;
  logic              r_write;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_done;
  logic              r_d_done;
  logic              r_timeout_err;

  logic              w_d_req;
  logic              w_fetch_turn;

  // Arbitration inputs: any data request, and whether fetch is owed the next grant.
  always_comb begin
    w_d_req      = d_rd | d_wr;
    w_fetch_turn = i_req && (r_dcnt == DC_W'(MAX_D_BURST));
  end

  // Arbiter FSM: grant, hold strobe through waitrequest, one-cycle response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_wcnt        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_req) r_dcnt <= '0;
          if (w_d_req && !w_fetch_turn) begin
            r_state <= GNT_D;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_wcnt  <= '0;
            if (d_wr) r_write <= 1'b1;
            else      r_read  <= 1'b1;
            if (i_req && (r_dcnt != DC_W'(MAX_D_BURST))) r_dcnt <= r_dcnt + DC_W'(1);
          end else if (i_req) begin
            r_state <= GNT_I;
            r_addr  <= i_addr;
            r_read  <= 1'b1;
            r_wcnt  <= '0;
            r_dcnt  <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_state <= RESP;
            if (r_state == GNT_I) begin
              r_i_done  <= 1'b1;
              r_i_rdata <= avm_readdata;
            end else begin
              r_d_done <= 1'b1;
              if (r_read) r_d_rdata <= avm_readdata;
            end
          end else if (r_wcnt == WC_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th stalled cycle: abandon with zero data.
            r_wcnt        <= r_wcnt + WC_W'(1);
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_state       <= RESP;
            r_timeout_err <= 1'b1;
            if (r_state == GNT_I) begin
              r_i_done  <= 1'b1;
              r_i_rdata <= '0;
            end else begin
              r_d_done  <= 1'b1;
              r_d_rdata <= '0;
            end
          end else begin
            r_wcnt <= r_wcnt + WC_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered state drives every output directly.
  always_comb begin
    avm_address    = r_addr;
    avm_read       = r_read;
    avm_write      = r_write;
    avm_writedata  = r_wdata;
    avm_byteenable = '1;
    i_rdata        = r_i_rdata;
    d_rdata        = r_d_rdata;
    i_done         = r_i_done;
    d_done         = r_d_done;
    timeout_err    = r_timeout_err;
  end

endmodule
